rot_addr_gen: RTL and testbench

ROT_ADDR_GEN -- requirements
Module: rot_addr_gen

---
 rtl/rot_addr_gen.sv | 213 +++++++++++++++++++++
 tb/tb_rot_addr_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rot_addr_gen.sv
// Rotation address generator: walks the padded image tile by tile, issuing TILE source-row
// read beats followed by TILE rotated destination-row write beats per tile.
module rot_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned TILE   = 8,
  parameter int unsigned BPP    = 3
) (
  input  logic              I_AG_HCLK,
  input  logic              I_AG_HRESET_N,
  input  logic              I_AG_CLEAR,
  input  logic              I_AG_START,
  input  logic [ADDR_W-1:0] I_AG_SRC_BASE,
  input  logic [ADDR_W-1:0] I_AG_DST_BASE,
  input  logic [DIM_W-1:0]  I_AG_HEIGHT,
  input  logic [DIM_W-1:0]  I_AG_WIDTH,
  input  logic [1:0]        I_AG_DEGREES,
  input  logic              I_AG_DIRECTION,
  input  logic              I_AG_READY,
  output logic              O_AG_VALID,
  output logic [ADDR_W-1:0] O_AG_ADDR,
  output logic              O_AG_WRITE,
  output logic              O_AG_PAD,
  output logic              O_AG_BUSY,
  output logic              O_AG_DONE,
  output logic              O_AG_ERR,
  output logic [DIM_W-1:0]  O_AG_NEW_H,
  output logic [DIM_W-1:0]  O_AG_NEW_W
);
  localparam int unsigned       BeatW     = $clog2(TILE);
  localparam logic [ADDR_W-1:0] BppA      = ADDR_W'(BPP);
  localparam logic [ADDR_W-1:0] TileA     = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] TileBytes = ADDR_W'(TILE * BPP);
  localparam logic [DIM_W:0]    RoundUp   = (DIM_W + 1)'(TILE - 1);
  localparam logic [DIM_W-1:0]  TileD     = DIM_W'(TILE);
  localparam logic [DIM_W-1:0]  OneD      = DIM_W'(1);
  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(TILE - 1);
  localparam logic [BeatW-1:0]  OneB      = BeatW'(1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d, write_q, write_d, pad_q, pad_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIM_W-1:0]    new_h_q, new_h_d, new_w_q, new_w_d, h_q, h_d, w_q, w_d;
  logic [DIM_W-1:0]    ht_q, ht_d, wt_q, wt_d, tr_q, tr_d, tc_q, tc_d;
  logic [DIM_W-1:0]    row_q, row_d, colend_q, colend_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [ADDR_W-1:0]   rstride_q, rstride_d, rstep_q, rstep_d, wstride_q, wstride_d;
  logic [ADDR_W-1:0]   dtr_q, dtr_d, dtc_q, dtc_d;
  logic [ADDR_W-1:0]   rcol_q, rcol_d, rtile_q, rtile_d, wcol_q, wcol_d, wtile_q, wtile_d;

  // Job setup values derived straight from the inputs, used only on an accepted START.
  logic [DIM_W:0]      nh_ext, nw_ext;
  logic [DIM_W-1:0]    nh_in, nw_in;
  logic [1:0]          angle_in;
  logic                bad_job;
  logic [ADDR_W-1:0]   nh_a, nw_a, wstride_in, wrow_tile, dtr_in, dtc_in, wcol_in;

  assign nh_ext   = ({1'b0, I_AG_HEIGHT} + RoundUp) & ~RoundUp;
  assign nw_ext   = ({1'b0, I_AG_WIDTH} + RoundUp) & ~RoundUp;
  assign nh_in    = nh_ext[DIM_W-1:0];
  assign nw_in    = nw_ext[DIM_W-1:0];
  assign angle_in = I_AG_DIRECTION ? I_AG_DEGREES : 2'd0 - I_AG_DEGREES;
  assign bad_job  = (I_AG_HEIGHT == '0) || (I_AG_WIDTH == '0) || nh_ext[DIM_W] || nw_ext[DIM_W];
  assign nh_a     = ADDR_W'(nh_in);
  assign nw_a     = ADDR_W'(nw_in);

  // Per-angle tile steps: dtr moves to the next tile row, dtc to the next tile column.
  always_comb begin
    wstride_in = (angle_in[0] ? nh_a : nw_a) * BppA;
    wrow_tile  = wstride_in * TileA;
    dtr_in     = wrow_tile;
    dtc_in     = TileBytes;
    wcol_in    = I_AG_DST_BASE;
    unique case (angle_in)
      2'd1: begin
        dtr_in  = '0 - TileBytes;
        dtc_in  = wrow_tile;
        wcol_in = I_AG_DST_BASE + (nh_a - TileA) * BppA;
      end
      2'd2: begin
        dtr_in  = '0 - wrow_tile;
        dtc_in  = '0 - TileBytes;
        wcol_in = I_AG_DST_BASE + ((nh_a - TileA) * nw_a + nw_a - TileA) * BppA;
      end
      2'd3: begin
        dtr_in  = TileBytes;
        dtc_in  = '0 - wrow_tile;
        wcol_in = I_AG_DST_BASE + (nw_a - TileA) * nh_a * BppA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;   valid_d = valid_q;     write_d = write_q;     pad_d = pad_q;
    busy_d = busy_q;     done_d = 1'b0;         err_d = 1'b0;          addr_d = addr_q;
    new_h_d = new_h_q;   new_w_d = new_w_q;     h_d = h_q;             w_d = w_q;
    ht_d = ht_q;         wt_d = wt_q;           tr_d = tr_q;           tc_d = tc_q;
    row_d = row_q;       colend_d = colend_q;   beat_d = beat_q;
    rstride_d = rstride_q; rstep_d = rstep_q;   wstride_d = wstride_q;
    dtr_d = dtr_q;       dtc_d = dtc_q;
    rcol_d = rcol_q;     rtile_d = rtile_q;     wcol_d = wcol_q;       wtile_d = wtile_q;

    if (I_AG_CLEAR) begin
      state_d = StIdle;  valid_d = 1'b0;  write_d = 1'b0;  pad_d = 1'b0;  busy_d = 1'b0;
      tr_d = '0;         tc_d = '0;       beat_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (I_AG_START) begin
            if (bad_job) begin
              err_d = 1'b1;
            end else begin
              state_d   = StRead;   valid_d = 1'b1;  write_d = 1'b0;  busy_d = 1'b1;
              new_h_d   = nh_in;    new_w_d = nw_in;
              h_d       = I_AG_HEIGHT;               w_d = I_AG_WIDTH;
              ht_d      = nh_in >> BeatW;            wt_d = nw_in >> BeatW;
              tr_d      = '0;       tc_d = '0;       beat_d = '0;
              row_d     = '0;       colend_d = TileD;
              pad_d     = TileD > I_AG_WIDTH;
              rstride_d = ADDR_W'(I_AG_WIDTH) * BppA;
              rstep_d   = ADDR_W'(I_AG_WIDTH) * BppA * TileA;
              wstride_d = wstride_in;
              dtr_d     = dtr_in;   dtc_d = dtc_in;
              addr_d    = I_AG_SRC_BASE;
              rcol_d    = I_AG_SRC_BASE;             rtile_d = I_AG_SRC_BASE;
              wcol_d    = wcol_in;                   wtile_d = wcol_in;
            end
          end
        end
        StRead: begin
          if (I_AG_READY) begin
            if (beat_q == LastBeat) begin
              state_d = StWrite;  write_d = 1'b1;  pad_d = 1'b0;
              beat_d  = '0;       addr_d  = wtile_q;
            end else begin
              beat_d = beat_q + OneB;
              row_d  = row_q + OneD;
              addr_d = addr_q + rstride_q;
              pad_d  = (row_d >= h_q) || (colend_q > w_q);
            end
          end
        end
        StWrite: begin
          if (I_AG_READY) begin
            if (beat_q != LastBeat) begin
              beat_d = beat_q + OneB;
              addr_d = addr_q + wstride_q;
            end else if (tr_q == ht_q - OneD && tc_q == wt_q - OneD) begin
              state_d = StIdle;  valid_d = 1'b0;  write_d = 1'b0;
              busy_d  = 1'b0;    done_d  = 1'b1;  beat_d  = '0;
            end else begin
              if (tr_q == ht_q - OneD) begin
                tr_d     = '0;
                tc_d     = tc_q + OneD;
                row_d    = '0;
                colend_d = colend_q + TileD;
                rcol_d   = rcol_q + TileBytes;
                rtile_d  = rcol_d;
                wcol_d   = wcol_q + dtc_q;
                wtile_d  = wcol_d;
              end else begin
                tr_d    = tr_q + OneD;
                row_d   = row_q + OneD;
                rtile_d = rtile_q + rstep_q;
                wtile_d = wtile_q + dtr_q;
              end
              state_d = StRead;  write_d = 1'b0;  beat_d = '0;
              addr_d  = rtile_d;
              pad_d   = (row_d >= h_q) || (colend_d > w_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I_AG_HCLK or negedge I_AG_HRESET_N) begin
    if (!I_AG_HRESET_N) begin
      state_q <= StIdle;  valid_q <= 1'b0;  write_q <= 1'b0;  pad_q <= 1'b0;
      busy_q <= 1'b0;     done_q <= 1'b0;   err_q <= 1'b0;    addr_q <= '0;
      new_h_q <= '0;      new_w_q <= '0;    h_q <= '0;        w_q <= '0;
      ht_q <= '0;         wt_q <= '0;       tr_q <= '0;       tc_q <= '0;
      row_q <= '0;        colend_q <= '0;   beat_q <= '0;
      rstride_q <= '0;    rstep_q <= '0;    wstride_q <= '0;  dtr_q <= '0;  dtc_q <= '0;
      rcol_q <= '0;       rtile_q <= '0;    wcol_q <= '0;     wtile_q <= '0;
    end else begin
      state_q <= state_d;  valid_q <= valid_d;  write_q <= write_d;  pad_q <= pad_d;
      busy_q <= busy_d;    done_q <= done_d;    err_q <= err_d;      addr_q <= addr_d;
      new_h_q <= new_h_d;  new_w_q <= new_w_d;  h_q <= h_d;          w_q <= w_d;
      ht_q <= ht_d;        wt_q <= wt_d;        tr_q <= tr_d;        tc_q <= tc_d;
      row_q <= row_d;      colend_q <= colend_d; beat_q <= beat_d;
      rstride_q <= rstride_d; rstep_q <= rstep_d; wstride_q <= wstride_d;
      dtr_q <= dtr_d;      dtc_q <= dtc_d;
      rcol_q <= rcol_d;    rtile_q <= rtile_d;  wcol_q <= wcol_d;    wtile_q <= wtile_d;
    end
  end

  assign O_AG_VALID = valid_q;
  assign O_AG_ADDR  = addr_q;
  assign O_AG_WRITE = write_q;
  assign O_AG_PAD   = pad_q;
  assign O_AG_BUSY  = busy_q;
  assign O_AG_DONE  = done_q;
  assign O_AG_ERR   = err_q;
  assign O_AG_NEW_H = new_h_q;
  assign O_AG_NEW_W = new_w_q;

endmodule

// File: tb/tb_rot_addr_gen.sv
// Directed plus randomized bench for rot_addr_gen; expected beats come from a tile-walk
// model that evaluates the address formulas directly for every beat.
module tb_rot_addr_gen;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;
  localparam int TILE   = 8;
  localparam int BPP    = 3;

  logic              clk, rst_n, clear, start, direction, ready;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [DIM_W-1:0]  height, width;
  logic [1:0]        degrees;
  logic              valid, write, pad, busy, done, err;
  logic [ADDR_W-1:0] addr;
  logic [DIM_W-1:0]  new_h, new_w;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic        pad;
  } beat_t;

  beat_t exp_q[$];
  int    exp_nh, exp_nw;

  rot_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .TILE(TILE), .BPP(BPP)) dut (
    .I_AG_HCLK(clk), .I_AG_HRESET_N(rst_n), .I_AG_CLEAR(clear), .I_AG_START(start),
    .I_AG_SRC_BASE(src_base), .I_AG_DST_BASE(dst_base), .I_AG_HEIGHT(height),
    .I_AG_WIDTH(width), .I_AG_DEGREES(degrees), .I_AG_DIRECTION(direction),
    .I_AG_READY(ready), .O_AG_VALID(valid), .O_AG_ADDR(addr), .O_AG_WRITE(write),
    .O_AG_PAD(pad), .O_AG_BUSY(busy), .O_AG_DONE(done), .O_AG_ERR(err),
    .O_AG_NEW_H(new_h), .O_AG_NEW_W(new_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference walk: tc outer, tr inner, TILE reads then TILE writes per tile.
  task automatic build_model(input int h, input int w, input int deg, input int dir,
                             input logic [31:0] src, input logic [31:0] dst);
    int    ht, wt, ang, wd, rd, cd;
    beat_t b;
    exp_nh = ((h + TILE - 1) / TILE) * TILE;
    exp_nw = ((w + TILE - 1) / TILE) * TILE;
    ht = exp_nh / TILE;
    wt = exp_nw / TILE;
    ang = dir ? deg : (4 - deg) % 4;
    wd = (ang % 2 == 0) ? exp_nw : exp_nh;
    exp_q.delete();
    for (int tc = 0; tc < wt; tc++) begin
      for (int tr = 0; tr < ht; tr++) begin
        for (int r = 0; r < TILE; r++) begin
          b.wr   = 1'b0;
          b.addr = src + 32'(((tr * TILE + r) * w + tc * TILE) * BPP);
          b.pad  = (tr * TILE + r >= h) || ((tc + 1) * TILE > w);
          exp_q.push_back(b);
        end
        for (int k = 0; k < TILE; k++) begin
          case (ang)
            0:       begin rd = tr * TILE + k;                     cd = tc * TILE;                end
            1:       begin rd = tc * TILE + k;                     cd = exp_nh - (tr + 1) * TILE; end
            2:       begin rd = exp_nh - (tr + 1) * TILE + k;      cd = exp_nw - (tc + 1) * TILE; end
            default: begin rd = exp_nw - (tc + 1) * TILE + k;      cd = tr * TILE;                end
          endcase
          b.wr   = 1'b1;
          b.addr = dst + 32'((rd * wd + cd) * BPP);
          b.pad  = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Leaves the bench at the negedge after the START edge (first beat visible).
  task automatic start_job(input int h, input int w, input int deg, input int dir,
                           input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk);
    height = 16'(h); width = 16'(w); degrees = 2'(deg); direction = dir[0];
    src_base = src; dst_base = dst; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input int h, input int w, input int deg,
                         input int dir, input logic [31:0] src, input logic [31:0] dst,
                         input int stall_at, input int stall_len, input bit rnd);
    int idx, cyc, stall_left;
    build_model(h, w, deg, dir, src, dst);
    start_job(h, w, deg, dir, src, dst);
    check({tag, " new_h"}, new_h, exp_nh);
    check({tag, " new_w"}, new_w, exp_nw);
    idx = 0; cyc = 0; stall_left = stall_len;
    while (idx < exp_q.size() && cyc < 20000) begin
      check({tag, " valid/done/busy"}, {valid, done, busy}, 3'b101);
      if (idx == stall_at && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      // A START while busy must be ignored, even with different job inputs.
      if (rnd && idx == 3) begin
        start = 1'b1; height = 16'($urandom_range(1, 60)); dst_base = $urandom;
      end else begin
        start = 1'b0;
      end
      if (ready) begin
        check({tag, " write"}, write, exp_q[idx].wr);
        check({tag, " addr"}, addr, exp_q[idx].addr);
        check({tag, " pad"}, pad, exp_q[idx].pad);
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; ready = 1'b1;
    check({tag, " beats_done"}, idx, exp_q.size());
    check({tag, " done"}, {done, busy, valid}, 3'b100);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 1'b0);
  endtask

  task automatic err_job(input string tag, input int h, input int w);
    int keep_h;
    keep_h = new_h;
    @(negedge clk);
    height = 16'(h); width = 16'(w); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " err"}, {err, busy, valid}, 3'b100);
    check({tag, " new_h_kept"}, new_h, keep_h);
    @(negedge clk);
    check({tag, " err_pulse"}, {err, busy, valid}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; ready = 1'b1; direction = 1'b1;
    degrees = '0; height = '0; width = '0; src_base = '0; dst_base = '0;
    repeat (2) @(negedge clk);
    check("reset ctrl", {valid, write, pad, busy, done, err}, 6'b0);
    check("reset addr", addr, 32'h0);
    check("reset new_h", new_h, 16'h0);
    check("reset new_w", new_w, 16'h0);
    rst_n = 1'b1;

    run_job("basic", 8, 8, 0, 1, 32'h1000, 32'h2000, -1, 0, 1'b0);
    run_job("rot90", 16, 8, 1, 1, 32'h0, 32'h0, -1, 0, 1'b0);
    run_job("pad", 10, 12, 0, 1, 32'h3000, 32'h8000, -1, 0, 1'b0);
    run_job("stall", 8, 8, 0, 1, 32'h1000, 32'h2000, 4, 3, 1'b0);
    run_job("ccw90", 9, 20, 1, 0, 32'h40, 32'h9000, -1, 0, 1'b0);

    err_job("h0", 0, 8);
    err_job("hmax", 16'hFFFF, 8);
    err_job("w0", 8, 0);

    // Asynchronous reset in the middle of a write phase.
    start_job(16, 16, 2, 1, 32'h100, 32'h200);
    for (int i = 0; i < 40 && !write; i++) @(negedge clk);
    check("reach write", write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst ctrl", {valid, write, pad, busy, done, err}, 6'b0);
    check("async rst addr", addr, 32'h0);
    check("async rst dims", {new_h, new_w}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("after_rst", 16, 16, 2, 1, 32'h100, 32'h200, -1, 0, 1'b0);

    // Soft clear during a read phase, then clear beating a START in idle.
    start_job(16, 8, 3, 1, 32'h500, 32'h600);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear state", {valid, busy, done}, 3'b000);
    check("clear dims", {new_h, new_w}, {16'd16, 16'd8});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clear no done", {valid, busy, done}, 3'b000);
    end
    height = 16'd8; width = 16'd8; clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clear beats start", {valid, busy, err}, 3'b000);
    run_job("after_clr", 16, 8, 3, 1, 32'h500, 32'h600, -1, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      run_job("rand", $urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(0, 3),
              $urandom_range(0, 1), (j % 2 == 1) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
              : $urandom, $urandom, -1, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
